// File: rtl/rx_data_checker.sv
// Checks an aligned byte stream against a fixed pattern or an incrementing sequence,
// counting checked words and mismatches per run and flagging a clean run as pass.
module rx_data_checker #(
    parameter int SETTLE_CYCLES = 16,
    parameter int PASS_WORDS    = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        lock,
    input  logic [7:0]  data_in,
    input  logic        mode,
    input  logic [7:0]  pattern,
    output logic        checking,
    output logic        err_pulse,
    output logic        err_sticky,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [31:0] word_cnt,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SEED   = 2'd2,
        CHECK  = 2'd3
    } state_t;

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [31:0] PASS_LIMIT  = 32'(PASS_WORDS);

    logic [1:0] r_rst_sync;
    logic       w_rst_n;
    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_settle_cnt;
    logic [7:0] r_expected;
    logic       r_mode;
    logic       w_start;
    logic       w_compare;
    logic       w_mismatch;
    logic [15:0] w_err_cnt_next;
    logic [31:0] w_word_cnt_next;

    // Assertion reaches everything immediately; release lands on the second edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n     = r_rst_sync[1];
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_start         = 1'b0;
        w_compare       = 1'b0;
        w_mismatch      = 1'b0;
        w_err_cnt_next  = err_cnt;
        w_word_cnt_next = word_cnt;
        case (r_state)
            IDLE: begin
                if (lock) begin
                    w_next_state = SETTLE;
                    w_start      = 1'b1;
                end
            end
            SETTLE: begin
                if (!lock) begin
                    w_next_state = IDLE;
                end else if (r_settle_cnt == SETTLE_LAST) begin
                    w_next_state = SEED;
                end
            end
            SEED: begin
                if (!lock) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = CHECK;
                end
            end
            CHECK: begin
                if (!lock) begin
                    w_next_state = IDLE;
                end else begin
                    w_compare  = 1'b1;
                    w_mismatch = (data_in != r_expected);
                end
            end
            default: w_next_state = IDLE;
        endcase

        if (w_start) begin
            w_err_cnt_next  = 16'h0000;
            w_word_cnt_next = 32'h0000_0000;
        end else if (w_compare) begin
            if (word_cnt != 32'hFFFF_FFFF) begin
                w_word_cnt_next = word_cnt + 32'd1;
            end
            if (w_mismatch && (err_cnt != 16'hFFFF)) begin
                w_err_cnt_next = err_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_settle_cnt <= 8'd0;
            r_expected   <= 8'd0;
            r_mode       <= 1'b0;
            checking     <= 1'b0;
            err_pulse    <= 1'b0;
            err_sticky   <= 1'b0;
            pass         <= 1'b0;
            err_cnt      <= 16'h0000;
            word_cnt     <= 32'h0000_0000;
        end else begin
            err_cnt   <= w_err_cnt_next;
            word_cnt  <= w_word_cnt_next;
            err_pulse <= w_compare && w_mismatch;
            checking  <= (w_next_state == CHECK);
            pass      <= (w_next_state == CHECK) && (w_word_cnt_next >= PASS_LIMIT)
                         && (w_err_cnt_next == 16'h0000);

            if (w_start) begin
                err_sticky <= 1'b0;
            end else if (w_compare && w_mismatch) begin
                err_sticky <= 1'b1;
            end

            if (w_start) begin
                r_settle_cnt <= 8'd0;
            end else if ((r_state == SETTLE) && (r_settle_cnt != SETTLE_LAST)) begin
                r_settle_cnt <= r_settle_cnt + 8'd1;
            end

            // Mode and reference are frozen here for the whole run.
            if (r_state == SEED) begin
                r_mode     <= mode;
                r_expected <= mode ? (data_in + 8'd1) : pattern;
            end else if (w_compare && r_mode) begin
                r_expected <= r_expected + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rx_data_checker.sv
// Directed bench for rx_data_checker: reset, counter-mode pass, single error, lock loss,
// mode freeze, expected-value independence from data, saturation and mid-run reset.
module tb_rx_data_checker;

    logic        clk;
    logic        rstn;
    logic        lock;
    logic [7:0]  data_in;
    logic        mode;
    logic [7:0]  pattern;
    logic        checking;
    logic        err_pulse;
    logic        err_sticky;
    logic        pass;
    logic [15:0] err_cnt;
    logic [31:0] word_cnt;
    logic [1:0]  o_dbg_state;

    int          total;
    int          bad;
    logic [7:0]  seq;
    logic        inc_data;
    logic        corrupt;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SEED   = 2'd2;
    localparam logic [1:0] S_CHECK  = 2'd3;

    rx_data_checker dut (
        .clk         (clk),
        .rstn        (rstn),
        .lock        (lock),
        .data_in     (data_in),
        .mode        (mode),
        .pattern     (pattern),
        .checking    (checking),
        .err_pulse   (err_pulse),
        .err_sticky  (err_sticky),
        .pass        (pass),
        .err_cnt     (err_cnt),
        .word_cnt    (word_cnt),
        .o_dbg_state (o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
        if (inc_data) begin
            seq     = seq + 8'd1;
            data_in = corrupt ? (seq ^ 8'h55) : seq;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 32'(o_dbg_state), 32'(S_IDLE));
        check({tag, "_outs"}, {28'd0, checking, err_pulse, err_sticky, pass}, 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        check({tag, "_word_cnt"}, word_cnt, 32'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        inc_data = 1'b0;
        corrupt  = 1'b0;
        seq      = 8'h00;
        rstn     = 1'b0;
        lock     = 1'b1;
        mode     = 1'b1;
        pattern  = 8'h00;
        data_in  = 8'($urandom_range(0, 255));

        // Reset held with lock high and random data
        for (int i = 0; i < 3; i++) begin
            tick();
            data_in = 8'($urandom_range(0, 255));
        end
        check_all_zero("rst_hold");

        seq      = 8'hF0;
        data_in  = 8'hF0;
        inc_data = 1'b1;
        rstn     = 1'b1;
        tick();
        check("rel_edge1_state", 32'(o_dbg_state), 32'(S_IDLE));
        tick();
        check("rel_edge2_state", 32'(o_dbg_state), 32'(S_IDLE));
        tick();
        check("rel_edge3_state", 32'(o_dbg_state), 32'(S_SETTLE));

        // Counter mode run
        ticks(15);
        check("cnt_settle_last", 32'(o_dbg_state), 32'(S_SETTLE));
        tick();
        check("cnt_seed_state", 32'(o_dbg_state), 32'(S_SEED));
        check("cnt_seed_checking", 32'(checking), 32'd0);
        tick();
        check("cnt_checking", 32'(checking), 32'd1);
        check("cnt_word0", word_cnt, 32'd0);
        ticks(1023);
        check("cnt_word1023", word_cnt, 32'd1023);
        check("cnt_pass_early", 32'(pass), 32'd0);
        tick();
        check("cnt_word1024", word_cnt, 32'd1024);
        check("cnt_pass", 32'(pass), 32'd1);
        check("cnt_err0", 32'(err_cnt), 32'd0);
        ticks(959);
        check("cnt_word1983", word_cnt, 32'd1983);
        check("cnt_pass_hold", 32'(pass), 32'd1);
        check("cnt_err_end", 32'(err_cnt), 32'd0);
        check("cnt_sticky", 32'(err_sticky), 32'd0);

        // Lock drop ends the run; counters hold
        lock = 1'b0;
        tick();
        check("drop1_state", 32'(o_dbg_state), 32'(S_IDLE));
        check("drop1_flags", {30'd0, checking, pass}, 32'd0);
        check("drop1_word_hold", word_cnt, 32'd1983);

        // Fixed pattern with single injected error
        inc_data = 1'b0;
        mode     = 1'b0;
        pattern  = 8'hA5;
        data_in  = 8'hA5;
        lock     = 1'b1;
        tick();
        check("fix_settle", 32'(o_dbg_state), 32'(S_SETTLE));
        check("fix_word_clr", word_cnt, 32'd0);
        ticks(16);
        check("fix_seed", 32'(o_dbg_state), 32'(S_SEED));
        tick();
        check("fix_checking", 32'(checking), 32'd1);
        ticks(5);
        check("fix_word5", word_cnt, 32'd5);
        check("fix_err0", 32'(err_cnt), 32'd0);
        data_in = 8'h5A;
        tick();
        data_in = 8'hA5;
        check("fix_pulse_hi", 32'(err_pulse), 32'd1);
        check("fix_err1", 32'(err_cnt), 32'd1);
        check("fix_sticky", 32'(err_sticky), 32'd1);
        check("fix_word6", word_cnt, 32'd6);
        tick();
        check("fix_pulse_lo", 32'(err_pulse), 32'd0);
        check("fix_err1_hold", 32'(err_cnt), 32'd1);
        check("fix_pass0", 32'(pass), 32'd0);

        // Second error, then lock lost for 3 cycles
        data_in = 8'h5A;
        tick();
        data_in = 8'hA5;
        tick();
        check("loss_err2", 32'(err_cnt), 32'd2);
        lock = 1'b0;
        tick();
        check("loss_state", 32'(o_dbg_state), 32'(S_IDLE));
        check("loss_err_hold", 32'(err_cnt), 32'd2);
        check("loss_word_hold", word_cnt, 32'd9);
        check("loss_checking", 32'(checking), 32'd0);
        ticks(2);
        check("loss_err_hold3", 32'(err_cnt), 32'd2);
        check("loss_sticky_hold", 32'(err_sticky), 32'd1);
        check("loss_pulse", 32'(err_pulse), 32'd0);
        lock = 1'b1;
        tick();
        check("ret_state", 32'(o_dbg_state), 32'(S_SETTLE));
        check("ret_err_clr", 32'(err_cnt), 32'd0);
        check("ret_word_clr", word_cnt, 32'd0);
        check("ret_sticky_clr", 32'(err_sticky), 32'd0);

        // Mode/pattern changes during CHECK are ignored
        ticks(16);
        tick();
        check("mchg_checking", 32'(checking), 32'd1);
        mode    = 1'b1;
        pattern = 8'h00;
        ticks(4);
        check("mchg_err0", 32'(err_cnt), 32'd0);
        check("mchg_word4", word_cnt, 32'd4);

        // One-cycle lock drop: IDLE, then SETTLE on the following edge
        lock = 1'b0;
        tick();
        lock = 1'b1;
        check("blip_idle", 32'(o_dbg_state), 32'(S_IDLE));
        check("blip_word_hold", word_cnt, 32'd4);
        seq      = 8'h10;
        data_in  = 8'h10;
        inc_data = 1'b1;
        tick();
        check("blip_settle", 32'(o_dbg_state), 32'(S_SETTLE));

        // Counter mode: a corrupted byte costs one error, expected keeps counting
        ticks(16);
        tick();
        check("inc_checking", 32'(checking), 32'd1);
        ticks(10);
        check("inc_err0", 32'(err_cnt), 32'd0);
        corrupt = 1'b1;
        tick();
        corrupt = 1'b0;
        tick();
        check("inc_pulse", 32'(err_pulse), 32'd1);
        check("inc_err1", 32'(err_cnt), 32'd1);
        ticks(6);
        check("inc_err1_hold", 32'(err_cnt), 32'd1);
        check("inc_word18", word_cnt, 32'd18);

        // Saturation with constant mismatch
        lock = 1'b0;
        tick();
        inc_data = 1'b0;
        mode     = 1'b0;
        pattern  = 8'h00;
        data_in  = 8'hFF;
        lock     = 1'b1;
        tick();
        ticks(17);
        check("sat_checking", 32'(checking), 32'd1);
        ticks(65534);
        check("sat_err_fffe", 32'(err_cnt), 32'h0000_FFFE);
        tick();
        check("sat_err_ffff", 32'(err_cnt), 32'h0000_FFFF);
        ticks(4465);
        check("sat_err_stuck", 32'(err_cnt), 32'h0000_FFFF);
        check("sat_word70000", word_cnt, 32'd70000);
        check("sat_pulse", 32'(err_pulse), 32'd1);
        check("sat_pass", 32'(pass), 32'd0);

        // Asynchronous reset mid-run
        #1;
        rstn = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        rstn = 1'b1;
        tick();
        check("midrel_edge1", 32'(o_dbg_state), 32'(S_IDLE));
        tick();
        check("midrel_edge2", 32'(o_dbg_state), 32'(S_IDLE));
        tick();
        check("midrel_edge3", 32'(o_dbg_state), 32'(S_SETTLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_data_checker.md
RX_DATA_CHECKER -- requirements
Module: rx_data_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: cycles ignored after lock rises before checking starts (range 1..255).
REQ-002 Parameter PASS_WORDS, default 1024: number of error-free checked words required to assert pass.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 lock  input  1  aligned-stream valid from the upstream frame aligner.
REQ-006 data_in  input  8  aligned byte from the upstream frame aligner, one per clk.
REQ-007 mode  input  1  0 = fixed-pattern check, 1 = incrementing-byte check.
REQ-008 pattern  input  8  expected byte in fixed-pattern mode.
REQ-009 checking  output  1  high while in CHECK state.
REQ-010 err_pulse  output  1  one-cycle pulse per mismatched word.
REQ-011 err_sticky  output  1  latched high after any mismatch until the next check run starts.
REQ-012 pass  output  1  high when the check run has PASS_WORDS or more words with zero errors.
REQ-013 err_cnt  output  16  mismatch count for the current run.
REQ-014 word_cnt  output  32  words checked in the current run.

Function
REQ-015 States SHALL be IDLE, SETTLE, SEED and CHECK, held in a registered state variable.
REQ-016 IDLE -> SETTLE when lock=1.
- On entry to SETTLE: clear err_cnt, word_cnt and err_sticky; load the settle counter with 0.
REQ-017 SETTLE -> SEED when the settle counter reaches SETTLE_CYCLES-1; data_in is ignored in SETTLE.
REQ-018 SEED -> CHECK after exactly one cycle.
- In SEED: capture mode and pattern.
- Expected value = pattern (mode 0) or data_in+1 mod 256 (mode 1).
REQ-019 Changes to mode and pattern after SEED SHALL have no effect until the next run.
REQ-020 In CHECK, every cycle compares data_in with expected and increments word_cnt.
- Mode 1: expected advances by +1 mod 256 every cycle from the previous expected value, not from data_in; 8'hFF wraps to 8'h00.
REQ-021 A mismatch SHALL do all of the following one cycle after the sampled word:
- increment err_cnt;
- assert err_pulse for exactly one cycle;
- set err_sticky.
REQ-022 err_cnt SHALL saturate at 16'hFFFF and word_cnt at 32'hFFFFFFFF; neither wraps.
REQ-023 pass SHALL be registered, asserted when state=CHECK, word_cnt>=PASS_WORDS and err_cnt=0, and deasserted otherwise.
- Once err_cnt>0, pass stays low for the rest of the run.
REQ-024 lock=0 in SETTLE, SEED or CHECK SHALL force IDLE on the next edge.
- err_cnt, word_cnt and err_sticky hold their values.
- checking and pass deassert.
- No compare is performed on that cycle.
REQ-025 lock re-asserting in the same cycle that IDLE is entered SHALL take effect only from IDLE, on the following edge.
REQ-026 checking SHALL be registered and equal to (state==CHECK).
- Latency from data_in sampled in CHECK to err_pulse/err_cnt/word_cnt update is 1 clk.

Reset
REQ-027 rstn low SHALL asynchronously force state IDLE and clear all outputs (checking, err_pulse, err_sticky, pass = 0; err_cnt = 16'h0000; word_cnt = 32'h0).
REQ-028 rstn SHALL pass through an internal two-flop synchronizer: assertion is asynchronous, deassertion takes effect on the second clk edge after rstn rises.
REQ-029 Reset asserted mid-run SHALL abort the run; after release the block waits in IDLE for lock.

Verification
REQ-030 Reset check: rstn low with lock=1 and random data -> all outputs 0, state IDLE; after release, SETTLE is entered no earlier than the third edge.
REQ-031 Counter-mode pass: mode=1, lock=1, data_in incrementing from 8'hF0 and wrapping through 8'hFF->8'h00 for 2000 cycles -> checking after SETTLE_CYCLES+1 cycles, err_cnt=0, pass=1 once word_cnt=1024.
REQ-032 Single error: mode=0, pattern=8'hA5; one byte 8'h5A injected in CHECK -> err_pulse high for exactly 1 cycle, err_cnt=1, err_sticky=1, pass remains 0.
REQ-033 Lock loss: lock dropped for 3 cycles mid-CHECK with err_cnt=2 -> IDLE, counters hold at 2; on lock return -> SETTLE, and counters clear to 0.
REQ-034 Saturation: mode=0 with constant mismatching data for 70000 CHECK cycles -> err_cnt stops at 16'hFFFF; word_cnt=70000.
REQ-035 Mode change: mode toggled from 0 to 1 during CHECK -> compare behaviour unchanged until the next SEED.
